dphy_hs_clk_lane_ctrl: RTL and testbench
========================================

Name: dphy_hs_clk_lane_ctrl

Overview:
Parametrised D-PHY clock-lane controller: the successor to the plain HS clock receiver. It runs on a free-running reference clock and tracks the clock-lane LP states (stop, HS request, ULPS). It sequences termination enable and the byte-clock divider CLR/CE, and reports when the HS byte clock is present. It sits beside the clock-lane buffers and gates the byte-clock domain of the CSI-2 receive path.

Parameters:
SYNC_STAGES, 2, synchroniser depth for the async LP pins and the HS toggle input (min 2)
LP_FILT_CYC, 4, consecutive identical synchronised LP samples required before the lane state is accepted (min 1)
TERM_EN_CYC, 8, clk_i cycles spent in LP-00 before hs_term_en_o asserts (min 1)
SETTLE_CYC, 24, clk_i cycles after termination enable before the divider is released (min 1)
ACT_WIN_CYC, 16, length in clk_i cycles of the activity-measurement window (min 2)
MIN_EDGES, 2, toggle edges per window needed to declare the HS clock active (1..ACT_WIN_CYC)

Ports:
clk_i  in  1  reference clock (≥ 2x byte clock)
rst_i  in  1  asynchronous active-high reset
lp_clk_p_i  in  1  clock-lane LP receiver, P line (async)
lp_clk_n_i  in  1  clock-lane LP receiver, N line (async)
hs_clk_toggle_i  in  1  toggles every byte-clock cycle in the byte domain (async here)
hs_term_en_o  out  1  enable HS differential termination
bufr_clr_o  out  1  clear to byte-clock divider
bufr_ce_o  out  1  clock enable to byte-clock divider
clk_active_o  out  1  HS byte clock present and stable
ulps_o  out  1  lane in ultra-low-power state
err_o  out  1  one-cycle pulse on an illegal LP sequence
state_o  out  3  current FSM state encoding

Behaviour:
- Decided interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - hs_term_en_o=0, bufr_clr_o=1, bufr_ce_o=0, clk_active_o=0, ulps_o=0, err_o=0, state_o=0.
  - Filtered LP value = 2'b11. All counters = 0.
- All outputs are registered and are decoded from the next state, so they change in the same cycle as state_o.
- LP filter:
  - Input pair {p,n} passes through SYNC_STAGES flops.
  - The filtered value updates once the synchronised value has held for LP_FILT_CYC consecutive cycles. Any mismatch restarts the count.
  - Latency from pin change to FSM state change is SYNC_STAGES+LP_FILT_CYC+1 cycles (+1 for sync uncertainty).
  - Glitches shorter than LP_FILT_CYC cycles are ignored.
- FSM (encoding in brackets). Transitions use the filtered LP value (LP):
  - STOP[0]: LP=01→HS_RQST; LP=10→ULPS_RQST; LP=00→ERROR; LP=11 stays.
  - HS_RQST[1]: LP=00→HS_PRPR; LP=11→STOP; LP=10→ERROR.
  - HS_PRPR[2]: counter counts TERM_EN_CYC cycles, then →HS_SETTLE. LP=11→STOP (abort); LP=01/10→ERROR.
  - HS_SETTLE[3]: counter counts SETTLE_CYC cycles, then →HS_ACTIVE. LP transitions as in HS_PRPR.
  - HS_ACTIVE[4]: LP=11→STOP (normal HS exit); LP=01/10→ERROR; LP=00 stays.
  - ULPS_RQST[5]: LP=00→ULPS; LP=11→STOP; LP=01→ERROR.
  - ULPS[6]: LP=10 stays (exit mark); LP=11→STOP; LP=01→ERROR.
  - ERROR[7]: stays until LP=11, then →STOP.
- Output decode:
  - hs_term_en_o=1 in HS_SETTLE and HS_ACTIVE.
  - bufr_clr_o=0 and bufr_ce_o=1 in HS_ACTIVE only.
  - ulps_o=1 in ULPS.
  - err_o pulses for 1 cycle on each entry into ERROR.
- Counters reset to 0 on every state entry. The counter width is $clog2 of the largest count.
- Activity monitor:
  - Toggle input is synchronised through SYNC_STAGES flops, then edge-detected (both edges count).
  - It runs only in HS_ACTIVE; the window counter restarts on HS_ACTIVE entry.
  - At each window end: clk_active_o ← (edges ≥ MIN_EDGES); edge count is cleared.
  - Consequence: clk_active_o first asserts one window after HS_ACTIVE entry, and deasserts within one window of clock loss.
  - An edge coinciding with window end counts toward the window that is closing.
- Leaving HS_ACTIVE clears clk_active_o in the same cycle as the state change.
- Reset asserted mid-operation returns everything to the reset values immediately (async). Release is synchronous to clk_i.
- Edge-count saturation: the counter saturates at ACT_WIN_CYC.

Test Plan:
- Defaults; LP 11→01→00, toggle every 2 cycles → state 1, 2, 3, 4. hs_term_en_o rises 8 cycles after state 2. bufr_ce_o=1 and bufr_clr_o=0 exactly 24 cycles later. clk_active_o=1 16 cycles after entering state 4.
- In HS_ACTIVE, stop the toggle → clk_active_o=0 at the next window end (≤16 cycles). Restart the toggle → clk_active_o=1 within 2 windows. Drive LP=11 → state 0, bufr_clr_o=1, hs_term_en_o=0.
- LP 11→10→00→10→11 → states 0, 5, 6, 6, 0. ulps_o=1 only in state 6. err_o stays 0.
- LP 11→00 directly → state 7 with a 1-cycle err_o pulse. LP=01 keeps state 7. LP=11 → state 0.
- Glitches on lp_clk_n_i of length 3 cycles (<LP_FILT_CYC) while in STOP → state_o stays 0. A 4-cycle stable 01 → state 1.
- Assert rst_i during HS_SETTLE → all outputs return to reset values without waiting for a clock edge. After release, the FSM is in STOP and needs a full LP-01/LP-00 sequence again.

Source files
------------

// File: rtl/dphy_hs_clk_lane_ctrl_if.sv
// ----------------------------------------------------------------------------
// dphy_hs_clk_lane_ctrl_if
// Pin and status bundle of the D-PHY clock-lane controller.
//   lp_clk_p_i / lp_clk_n_i : clock-lane LP receiver outputs (asynchronous)
//   hs_clk_toggle_i         : byte-domain toggle, flips every byte clock (async)
//   hs_term_en_o            : HS differential termination enable
//   bufr_clr_o / bufr_ce_o  : byte-clock divider clear / clock enable
//   clk_active_o            : HS byte clock present and stable
//   ulps_o                  : lane is in ultra-low-power state
//   err_o                   : one-cycle pulse on an illegal LP sequence
//   state_o                 : current FSM state encoding
// Modports: master = PHY/buffer side driving the pins, slave = the controller.
// ----------------------------------------------------------------------------
interface dphy_hs_clk_lane_ctrl_if;
    logic       lp_clk_p_i;
    logic       lp_clk_n_i;
    logic       hs_clk_toggle_i;
    logic       hs_term_en_o;
    logic       bufr_clr_o;
    logic       bufr_ce_o;
    logic       clk_active_o;
    logic       ulps_o;
    logic       err_o;
    logic [2:0] state_o;

    modport master (
        output lp_clk_p_i, lp_clk_n_i, hs_clk_toggle_i,
        input  hs_term_en_o, bufr_clr_o, bufr_ce_o, clk_active_o,
               ulps_o, err_o, state_o
    );

    modport slave (
        input  lp_clk_p_i, lp_clk_n_i, hs_clk_toggle_i,
        output hs_term_en_o, bufr_clr_o, bufr_ce_o, clk_active_o,
               ulps_o, err_o, state_o
    );
endinterface

// File: rtl/dphy_hs_clk_lane_ctrl.sv
// ----------------------------------------------------------------------------
// dphy_hs_clk_lane_ctrl
// D-PHY clock-lane controller running on a free-running reference clock.
// Filters the clock-lane LP pins, walks the lane through stop / HS / ULPS
// states, sequences termination and the byte-clock divider, and monitors the
// HS byte-clock toggle to report when the byte clock is really running.
// Ports:
//   clk_i : reference clock (at least twice the byte clock)
//   rst_i : asynchronous active-high reset, released synchronously
//   lane  : dphy_hs_clk_lane_ctrl_if.slave (LP pins, toggle, all status)
// ----------------------------------------------------------------------------
module dphy_hs_clk_lane_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LP_FILT_CYC = 4,
    parameter int TERM_EN_CYC = 8,
    parameter int SETTLE_CYC  = 24,
    parameter int ACT_WIN_CYC = 16,
    parameter int MIN_EDGES   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    dphy_hs_clk_lane_ctrl_if.slave       lane
);

    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_HS_RQST   = 3'd1,
        ST_HS_PRPR   = 3'd2,
        ST_HS_SETTLE = 3'd3,
        ST_HS_ACTIVE = 3'd4,
        ST_ULPS_RQST = 3'd5,
        ST_ULPS      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    // One shared counter times PRPR, SETTLE and the activity window.
    localparam int CNT_MAX = (TERM_EN_CYC > SETTLE_CYC)
                           ? ((TERM_EN_CYC > ACT_WIN_CYC) ? TERM_EN_CYC : ACT_WIN_CYC)
                           : ((SETTLE_CYC  > ACT_WIN_CYC) ? SETTLE_CYC  : ACT_WIN_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int RUN_W   = $clog2(LP_FILT_CYC + 1);
    localparam int EDGE_W  = $clog2(ACT_WIN_CYC + 1);

    logic [SYNC_STAGES-1:0] p_sync, n_sync, t_sync;
    logic [1:0]             lp_sync, lp_cand, lp_filt;
    logic [RUN_W-1:0]       run_q, run_nxt;
    logic                   tog_last;
    logic                   edge_now;
    logic [EDGE_W-1:0]      edges_q;
    logic [EDGE_W:0]        edge_sum;
    logic [CNT_W-1:0]       cnt_q;
    logic                   win_end;
    state_t                 state_q, next_state;

    // ---------------- synchronisers (LP pins idle high, toggle low) --------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_sync   <= '1;
            n_sync   <= '1;
            t_sync   <= '0;
            tog_last <= 1'b0;
        end else begin
            p_sync   <= {p_sync[SYNC_STAGES-2:0], lane.lp_clk_p_i};
            n_sync   <= {n_sync[SYNC_STAGES-2:0], lane.lp_clk_n_i};
            t_sync   <= {t_sync[SYNC_STAGES-2:0], lane.hs_clk_toggle_i};
            tog_last <= t_sync[SYNC_STAGES-1];
        end
    end

    assign lp_sync  = {p_sync[SYNC_STAGES-1], n_sync[SYNC_STAGES-1]};
    assign edge_now = t_sync[SYNC_STAGES-1] ^ tog_last;

    // ---------------- LP glitch filter --------------------------------------
    // run_nxt is the number of consecutive samples equal to the current one,
    // including this one; the filtered value is accepted on the Nth sample.
    always_comb begin
        if (lp_sync != lp_cand)
            run_nxt = RUN_W'(1);
        else if (run_q == RUN_W'(LP_FILT_CYC))
            run_nxt = run_q;
        else
            run_nxt = run_q + RUN_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lp_cand <= 2'b11;
            lp_filt <= 2'b11;
            run_q   <= '0;
        end else begin
            lp_cand <= lp_sync;
            run_q   <= run_nxt;
            if (run_nxt == RUN_W'(LP_FILT_CYC))
                lp_filt <= lp_sync;
        end
    end

    // ---------------- FSM ---------------------------------------------------
    assign win_end = (state_q == ST_HS_ACTIVE) && (cnt_q == CNT_W'(ACT_WIN_CYC - 1));

    // NOTE: next_state gets its default before the case so no path through
    // this block leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_STOP: begin
                if      (lp_filt == 2'b01) next_state = ST_HS_RQST;
                else if (lp_filt == 2'b10) next_state = ST_ULPS_RQST;
                else if (lp_filt == 2'b00) next_state = ST_ERROR;
            end
            ST_HS_RQST: begin
                if      (lp_filt == 2'b00) next_state = ST_HS_PRPR;
                else if (lp_filt == 2'b11) next_state = ST_STOP;
                else if (lp_filt == 2'b10) next_state = ST_ERROR;
            end
            ST_HS_PRPR, ST_HS_SETTLE: begin
                // LP aborts take priority over the timer expiring.
                if (lp_filt == 2'b11)
                    next_state = ST_STOP;
                else if (lp_filt != 2'b00)
                    next_state = ST_ERROR;
                else if (state_q == ST_HS_PRPR && cnt_q == CNT_W'(TERM_EN_CYC - 1))
                    next_state = ST_HS_SETTLE;
                else if (state_q == ST_HS_SETTLE && cnt_q == CNT_W'(SETTLE_CYC - 1))
                    next_state = ST_HS_ACTIVE;
            end
            ST_HS_ACTIVE: begin
                if      (lp_filt == 2'b11) next_state = ST_STOP;
                else if (lp_filt != 2'b00) next_state = ST_ERROR;
            end
            ST_ULPS_RQST: begin
                if      (lp_filt == 2'b00) next_state = ST_ULPS;
                else if (lp_filt == 2'b11) next_state = ST_STOP;
                else if (lp_filt == 2'b01) next_state = ST_ERROR;
            end
            ST_ULPS: begin
                if      (lp_filt == 2'b11) next_state = ST_STOP;
                else if (lp_filt == 2'b01) next_state = ST_ERROR;
            end
            ST_ERROR: begin
                if (lp_filt == 2'b11) next_state = ST_STOP;
            end
            default: next_state = ST_STOP;
        endcase
    end

    assign edge_sum = {1'b0, edges_q} + (EDGE_W + 1)'(edge_now);

    // State, counter and registered outputs decoded from next_state so they
    // all move in the same cycle as state_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= ST_STOP;
            cnt_q             <= '0;
            edges_q           <= '0;
            lane.hs_term_en_o <= 1'b0;
            lane.bufr_clr_o   <= 1'b1;
            lane.bufr_ce_o    <= 1'b0;
            lane.clk_active_o <= 1'b0;
            lane.ulps_o       <= 1'b0;
            lane.err_o        <= 1'b0;
        end else begin
            state_q <= next_state;

            if (next_state != state_q || win_end)
                cnt_q <= '0;
            else if (state_q == ST_HS_PRPR || state_q == ST_HS_SETTLE ||
                     state_q == ST_HS_ACTIVE)
                cnt_q <= cnt_q + CNT_W'(1);

            // Activity monitor: only counts while staying in HS_ACTIVE; an
            // edge landing on the window end belongs to the closing window.
            if (next_state != ST_HS_ACTIVE || state_q != ST_HS_ACTIVE) begin
                edges_q           <= '0;
                lane.clk_active_o <= 1'b0;
            end else if (win_end) begin
                edges_q           <= '0;
                lane.clk_active_o <= (edge_sum >= (EDGE_W + 1)'(MIN_EDGES));
            end else if (edge_sum > (EDGE_W + 1)'(ACT_WIN_CYC)) begin
                edges_q           <= EDGE_W'(ACT_WIN_CYC);
            end else begin
                edges_q           <= edge_sum[EDGE_W-1:0];
            end

            lane.hs_term_en_o <= (next_state == ST_HS_SETTLE) || (next_state == ST_HS_ACTIVE);
            lane.bufr_clr_o   <= (next_state != ST_HS_ACTIVE);
            lane.bufr_ce_o    <= (next_state == ST_HS_ACTIVE);
            lane.ulps_o       <= (next_state == ST_ULPS);
            lane.err_o        <= (next_state == ST_ERROR) && (state_q != ST_ERROR);
        end
    end

    assign lane.state_o = state_q;

endmodule

// File: tb/tb_dphy_hs_clk_lane_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dphy_hs_clk_lane_ctrl
// Directed self-checking bench for the D-PHY clock-lane controller with the
// default parameter set. Expected values are hand-derived timing constants.
// ----------------------------------------------------------------------------
module tb_dphy_hs_clk_lane_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic tog_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   err_seen = 0;

    dphy_hs_clk_lane_ctrl_if lane ();

    dphy_hs_clk_lane_ctrl #(
        .SYNC_STAGES (2),
        .LP_FILT_CYC (4),
        .TERM_EN_CYC (8),
        .SETTLE_CYC  (24),
        .ACT_WIN_CYC (16),
        .MIN_EDGES   (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .lane  (lane.slave)
    );

    always #5 clk = ~clk;

    // Byte-domain stand-in: flips every second reference cycle while enabled.
    initial begin
        bit ph;
        ph = 1'b0;
        lane.hs_clk_toggle_i = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (tog_en) begin
                ph = ~ph;
                if (ph) lane.hs_clk_toggle_i = ~lane.hs_clk_toggle_i;
            end
        end
    end

    // Counts cycles with err_o high, sampled away from the active edge.
    always @(negedge clk) if (lane.err_o === 1'b1) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lp(input logic p, input logic n);
        lane.lp_clk_p_i = p;
        lane.lp_clk_n_i = n;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return lane.hs_term_en_o;
            1:       return lane.bufr_ce_o;
            2:       return lane.clk_active_o;
            default: return lane.ulps_o;
        endcase
    endfunction

    task automatic wait_state(input logic [2:0] exp, input int max, output int n);
        n = 0;
        while (lane.state_o !== exp && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_for(input int sel, input logic val, input int max, output int n);
        n = 0;
        while (probe(sel) !== val && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int err_base;
        int bad_cycles;
        bit seen1;

        // ---------------- reset values ----------------
        rst = 1'b1;
        set_lp(1'b1, 1'b1);
        repeat (3) tick();
        check("rst_state",  32'(lane.state_o),      0);
        check("rst_term",   32'(lane.hs_term_en_o), 0);
        check("rst_clr",    32'(lane.bufr_clr_o),   1);
        check("rst_ce",     32'(lane.bufr_ce_o),    0);
        check("rst_active", 32'(lane.clk_active_o), 0);
        check("rst_ulps",   32'(lane.ulps_o),       0);
        check("rst_err",    32'(lane.err_o),        0);
        rst = 1'b0;
        repeat (5) tick();

        // ---------------- HS entry sequence ----------------
        tog_en = 1'b1;
        set_lp(1'b0, 1'b1);
        wait_state(3'd1, 20, n);
        check("hs_rqst_state", 32'(lane.state_o), 1);
        check("lp_latency", n, 7);                  // SYNC_STAGES + LP_FILT_CYC + 1
        set_lp(1'b0, 1'b0);
        wait_state(3'd2, 20, n);
        check("hs_prpr_state", 32'(lane.state_o), 2);
        check("prpr_term", 32'(lane.hs_term_en_o), 0);
        wait_for(0, 1'b1, 20, n);
        check("term_delay", n, 8);
        check("settle_state", 32'(lane.state_o), 3);
        wait_for(1, 1'b1, 40, n);
        check("ce_delay", n, 24);
        check("active_clr", 32'(lane.bufr_clr_o), 0);
        check("active_state", 32'(lane.state_o), 4);
        wait_for(2, 1'b1, 40, n);
        check("clk_active_delay", n, 16);

        // ---------------- clock loss and recovery ----------------
        tog_en = 1'b0;
        wait_for(2, 1'b0, 24, n);
        check("loss_active", 32'(lane.clk_active_o), 0);
        check("loss_within_window", 32'(n <= 16), 1);
        tog_en = 1'b1;
        wait_for(2, 1'b1, 40, n);
        check("recover_active", 32'(lane.clk_active_o), 1);
        check("recover_within_2win", 32'(n <= 32), 1);
        set_lp(1'b1, 1'b1);
        wait_state(3'd0, 20, n);
        check("hs_exit_state", 32'(lane.state_o), 0);
        check("hs_exit_clr", 32'(lane.bufr_clr_o), 1);
        check("hs_exit_term", 32'(lane.hs_term_en_o), 0);
        check("hs_exit_ce", 32'(lane.bufr_ce_o), 0);
        check("hs_exit_active", 32'(lane.clk_active_o), 0);
        tog_en = 1'b0;
        repeat (4) tick();

        // ---------------- ULPS entry / exit ----------------
        err_base = err_seen;
        set_lp(1'b1, 1'b0);
        wait_state(3'd5, 20, n);
        check("ulps_rqst_state", 32'(lane.state_o), 5);
        check("ulps_rqst_ulps", 32'(lane.ulps_o), 0);
        set_lp(1'b0, 1'b0);
        wait_state(3'd6, 20, n);
        check("ulps_state", 32'(lane.state_o), 6);
        check("ulps_flag", 32'(lane.ulps_o), 1);
        set_lp(1'b1, 1'b0);
        repeat (12) tick();
        check("ulps_mark_state", 32'(lane.state_o), 6);
        check("ulps_mark_flag", 32'(lane.ulps_o), 1);
        set_lp(1'b1, 1'b1);
        wait_state(3'd0, 20, n);
        check("ulps_exit_state", 32'(lane.state_o), 0);
        check("ulps_exit_flag", 32'(lane.ulps_o), 0);
        check("ulps_no_err", err_seen - err_base, 0);

        // ---------------- illegal LP-00 from STOP ----------------
        err_base = err_seen;
        set_lp(1'b0, 1'b0);
        wait_state(3'd7, 20, n);
        check("error_state", 32'(lane.state_o), 7);
        repeat (4) tick();
        check("err_pulse_cycles", err_seen - err_base, 1);
        set_lp(1'b0, 1'b1);
        repeat (12) tick();
        check("error_hold_01", 32'(lane.state_o), 7);
        set_lp(1'b1, 1'b1);
        wait_state(3'd0, 20, n);
        check("error_exit_state", 32'(lane.state_o), 0);
        check("error_no_repulse", err_seen - err_base, 1);

        // ---------------- glitch rejection ----------------
        bad_cycles = 0;
        set_lp(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i == 3) set_lp(1'b1, 1'b1);
            tick();
            if (lane.state_o !== 3'd0) bad_cycles++;
        end
        check("glitch_3cyc_ignored", bad_cycles, 0);
        seen1 = 1'b0;
        set_lp(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i == 4) set_lp(1'b1, 1'b1);
            tick();
            if (lane.state_o === 3'd1) seen1 = 1'b1;
        end
        check("stable_4cyc_accepted", 32'(seen1), 1);
        wait_state(3'd0, 20, n);
        check("after_pulse_stop", 32'(lane.state_o), 0);

        // ---------------- async reset during HS_SETTLE ----------------
        set_lp(1'b0, 1'b1);
        wait_state(3'd1, 20, n);
        set_lp(1'b0, 1'b0);
        wait_state(3'd3, 40, n);
        check("pre_rst_settle", 32'(lane.state_o), 3);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(lane.state_o),      0);
        check("async_rst_term",  32'(lane.hs_term_en_o), 0);
        check("async_rst_clr",   32'(lane.bufr_clr_o),   1);
        check("async_rst_ce",    32'(lane.bufr_ce_o),    0);
        set_lp(1'b1, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("post_rst_stop", 32'(lane.state_o), 0);
        check("post_rst_term", 32'(lane.hs_term_en_o), 0);
        set_lp(1'b0, 1'b1);
        wait_state(3'd1, 20, n);
        check("post_rst_rqst", 32'(lane.state_o), 1);
        set_lp(1'b0, 1'b0);
        wait_state(3'd2, 20, n);
        check("post_rst_prpr", 32'(lane.state_o), 2);
        check("post_rst_prpr_term", 32'(lane.hs_term_en_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
